branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side branch direction/target predictor.
//  - Predicts conditional branches at IF so fetch can follow them speculatively.
//  - Consumes branch outcomes resolved in EX (take_branch from branch resolution).
//  - Direct-mapped table: valid, tag, target and a 2-bit saturating counter per entry.
//  - On a wrong prediction, emits a registered redirect (correct next PC) for fetch/flush.
// PARAMETERS
//  XLEN      32  PC/target width in bits
//  IDX_BITS  4   index width; table holds 2**IDX_BITS entries
//  TAG_BITS  8   stored tag width, taken from pc[IDX_BITS+2 +: TAG_BITS]
// PORTS
//  clk             in   1         core clock, rising edge
//  reset_n         in   1         asynchronous active-low reset
//  if_pc           in   XLEN      PC being fetched
//  pred_taken      out  1         predict taken for if_pc (combinational)
//  pred_target     out  XLEN      predicted target; if_pc+4 when pred_taken=0
//  upd_valid       in   1         EX retires a conditional branch this cycle
//  upd_pc          in   XLEN      PC of that branch
//  upd_taken       in   1         resolved direction (take_branch)
//  upd_target      in   XLEN      resolved taken target
//  upd_pred_taken  in   1         prediction that was carried down the pipe with it
//  upd_pred_target in   XLEN      predicted target carried with it
//  flush_table     in   1         synchronous invalidate of all entries
//  redirect_valid  out  1         1-cycle pulse: previous update mispredicted
//  redirect_pc     out  XLEN      correct next PC for that branch
// BEHAVIOUR
//  Reset (reset_n=0, async):
//  - All valid bits clear; all counters = 2'b01 (weak not-taken).
//  - redirect_valid=0, redirect_pc=0.
//  - pred_taken=0 and pred_target=if_pc+4 while the table is empty.
//  Index and tag:
//  - idx = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+2 +: TAG_BITS]; pc[1:0] ignored.
//  Lookup (combinational, from registered table state):
//  - hit = valid[idx] && tag match.
//  - pred_taken = hit && ctr[idx][1].
//  - pred_target = pred_taken ? target[idx] : if_pc+4.
//  - The +4 add wraps modulo 2**XLEN.
//  Update (clocked, when upd_valid=1):
//  - Hit: counter +1 if upd_taken, -1 otherwise; saturates at 2'b11 and 2'b00.
//    target is rewritten only when upd_taken=1.
//  - Miss: allocate the entry (valid=1, tag, target=upd_target); this evicts any
//    previous occupant. New counter = 2'b10 if taken, 2'b01 if not taken.
//  Mispredict detection (registered, valid the cycle after upd_valid):
//  - mis = (upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target).
//  - redirect_valid <= upd_valid && mis.
//  - redirect_pc <= upd_taken ? upd_target : upd_pc+4.
//  - redirect_pc holds its value while redirect_valid=0.
//  Simultaneous events:
//  - Lookup and update to the same idx in one cycle: the lookup sees the old
//    contents; the new contents are visible from the next cycle (no bypass).
//  - flush_table together with upd_valid: flush wins. All entries are invalid next
//    cycle, but redirect still computes from the upd_* inputs.
//  - reset_n asserted mid-update: the update is discarded and the reset state
//    applies immediately.
//  Table state has no X: unwritten entries are fully defined by reset.
// TESTING
//  1 Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104, redirect_valid=0.
//  2 upd pc=0x100 taken tgt=0x200 pred=0 -> next cycle redirect_valid=1,
//    redirect_pc=0x200; then if_pc=0x100 -> pred_taken=1, pred_target=0x200.
//  3 Four not-taken updates at 0x100 after test 2: counter goes 10->01->00->00
//    (saturates); pred_taken=0 after the first; redirect_pc=0x104 on the first only.
//  4 Alias: update 0x140 (same idx, different tag, IDX_BITS=4) taken -> 0x100 now
//    misses (pred_taken=0) and 0x140 hits with a counter of 10.
//  5 Same-cycle lookup and update on idx 0 -> pred_* reflect the old entry that
//    cycle and the new entry the following cycle.
//  6 flush_table with upd_valid mispredicted -> table empty next cycle, redirect
//    still pulses; reset_n low mid-update -> redirect_valid=0 at once, table empty.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/EX <-> branch predictor signal bundle.
interface branch_predictor_if #(
  parameter int unsigned XLEN = 32
);
  logic            if_pc_dummy_unused_never;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            flush_table;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Pipeline side: supplies fetch PC and resolved branches, consumes predictions.
  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush_table,
    input  pred_taken, pred_target, redirect_valid, redirect_pc
  );

  // Predictor side.
  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush_table,
    output pred_taken, pred_target, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: valid/tag/target/2-bit counter per entry,
// combinational lookup at IF, clocked update from EX, registered redirect.
module branch_predictor #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  branch_predictor_if.slave bp
);
  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int unsigned TAG_LSB = IDX_BITS + 2;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0]     tgt_q [ENTRIES];
  logic [1:0]          ctr_q [ENTRIES];

  logic                redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                lk_hit, up_hit, mis, tgt_we;
  logic [1:0]          ctr_d;

  // Lookup from registered table state; no bypass of a same-cycle update.
  always_comb begin
    lk_idx         = bp.if_pc[IDX_BITS+1:2];
    lk_tag         = bp.if_pc[TAG_LSB +: TAG_BITS];
    lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bp.pred_taken  = lk_hit && ctr_q[lk_idx][1];
    bp.pred_target = bp.pred_taken ? tgt_q[lk_idx] : bp.if_pc + XLEN'(4);
  end

  // Next entry contents and mispredict decision for the branch being retired.
  always_comb begin
    ctr_d  = 2'b01;
    tgt_we = 1'b1;
    up_idx = bp.upd_pc[IDX_BITS+1:2];
    up_tag = bp.upd_pc[TAG_LSB +: TAG_BITS];
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    if (up_hit) begin
      tgt_we = bp.upd_taken;
      if (bp.upd_taken) begin
        ctr_d = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
      end else begin
        ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
      end
    end else begin
      ctr_d = bp.upd_taken ? 2'b10 : 2'b01;
    end
    mis = (bp.upd_taken != bp.upd_pred_taken) ||
          (bp.upd_taken && (bp.upd_target != bp.upd_pred_target));
    redirect_valid_d = bp.upd_valid && mis;
    redirect_pc_d    = redirect_pc_q;
    if (redirect_valid_d) begin
      redirect_pc_d = bp.upd_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
    end
  end

  // Table storage: flush beats update; a miss evicts the previous occupant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (bp.flush_table) begin
      valid_q <= '0;
    end else if (bp.upd_valid) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      ctr_q[up_idx]   <= ctr_d;
      if (tgt_we) begin
        tgt_q[up_idx] <= bp.upd_target;
      end
    end
  end

  // Redirect pulse and held correct-PC register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bp.redirect_valid = redirect_valid_q;
  assign bp.redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: table model checked every cycle plus directed literals.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset_n;
  bit   check_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32)) bp ();

  branch_predictor #(.XLEN(32), .IDX_BITS(4), .TAG_BITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bp      (bp)
  );

  // Reference table: 16 entries, index = word address mod 16, tag = pc/64 mod 256.
  bit          m_valid [16];
  int          m_tag   [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];
  logic        m_rv;
  logic [31:0] m_rpc;
  int          mi;
  bit          mmis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> 6) % 32'd256);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state update, applied on the same edges the hardware reacts to.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 32'h0;
      end
      m_rv  = 1'b0;
      m_rpc = 32'h0;
    end else begin
      mmis = (bp.upd_taken != bp.upd_pred_taken) ||
             (bp.upd_taken && (bp.upd_target != bp.upd_pred_target));
      m_rv = bp.upd_valid && mmis;
      if (m_rv) m_rpc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
      if (bp.flush_table) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (bp.upd_valid) begin
        mi = idx_of(bp.upd_pc);
        if (m_valid[mi] && m_tag[mi] == tag_of(bp.upd_pc)) begin
          if (bp.upd_taken) begin
            m_ctr[mi] = (m_ctr[mi] < 3) ? m_ctr[mi] + 1 : 3;
            m_tgt[mi] = bp.upd_target;
          end else begin
            m_ctr[mi] = (m_ctr[mi] > 0) ? m_ctr[mi] - 1 : 0;
          end
        end else begin
          m_valid[mi] = 1'b1;
          m_tag[mi]   = tag_of(bp.upd_pc);
          m_tgt[mi]   = bp.upd_target;
          m_ctr[mi]   = bp.upd_taken ? 2 : 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  int          ci;
  bit          e_pt;
  logic [31:0] e_ptgt;
  always @(negedge clk) begin
    if (check_en) begin
      ci     = idx_of(bp.if_pc);
      e_pt   = m_valid[ci] && (m_tag[ci] == tag_of(bp.if_pc)) && (m_ctr[ci] >= 2);
      e_ptgt = e_pt ? m_tgt[ci] : bp.if_pc + 32'd4;
      chk("model_pred_taken",  32'(bp.pred_taken), 32'(e_pt));
      chk("model_pred_target", bp.pred_target, e_ptgt);
      chk("model_redirect_valid", 32'(bp.redirect_valid), 32'(m_rv));
      chk("model_redirect_pc", bp.redirect_pc, m_rpc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ppt, input logic [31:0] ptgt);
    bp.upd_valid       = 1'b1;
    bp.upd_pc          = pc;
    bp.upd_taken       = tk;
    bp.upd_target      = tgt;
    bp.upd_pred_taken  = ppt;
    bp.upd_pred_target = ptgt;
  endtask

  task automatic clr();
    bp.upd_valid   = 1'b0;
    bp.flush_table = 1'b0;
  endtask

  // One update: apply for one edge, then idle; caller checks at the following negedge.
  task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ppt, input logic [31:0] ptgt);
    tick();
    set_upd(pc, tk, tgt, ppt, ptgt);
    tick();
    clr();
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic pt, input logic [31:0] ptgt,
                         input logic rv, input logic [31:0] rpc);
    chk({name, "_pred_taken"},  32'(bp.pred_taken), 32'(pt));
    chk({name, "_pred_target"}, bp.pred_target, ptgt);
    chk({name, "_redirect_valid"}, 32'(bp.redirect_valid), 32'(rv));
    chk({name, "_redirect_pc"}, bp.redirect_pc, rpc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bp.if_pc = 32'h100;
    bp.upd_valid = 1'b0; bp.upd_pc = '0; bp.upd_taken = 1'b0; bp.upd_target = '0;
    bp.upd_pred_taken = 1'b0; bp.upd_pred_target = '0; bp.flush_table = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    check_en = 1'b1;

    // Empty table after reset; +4 wraps at the top of the address space.
    @(negedge clk);
    chk_out("t1_reset", 1'b0, 32'h104, 1'b0, 32'h0);
    tick(); bp.if_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("t1_wrap_target", bp.pred_target, 32'h0);
    tick(); bp.if_pc = 32'h100;

    // First taken branch allocates and redirects.
    do_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    chk_out("t2_alloc", 1'b1, 32'h200, 1'b1, 32'h200);

    // Counter walks down and saturates at 00.
    do_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    chk_out("t3_nt1", 1'b0, 32'h104, 1'b1, 32'h104);
    do_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_out("t3_nt2", 1'b0, 32'h104, 1'b0, 32'h104);
    do_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    do_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_out("t3_nt4", 1'b0, 32'h104, 1'b0, 32'h104);
    do_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    chk_out("t3_sat_then_taken", 1'b0, 32'h104, 1'b1, 32'h200);

    // Alias on idx 0: 0x140 evicts 0x100 and starts at weak taken.
    do_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    chk_out("t4_old_miss", 1'b0, 32'h104, 1'b1, 32'h300);
    tick(); bp.if_pc = 32'h140;
    @(negedge clk);
    chk("t4_new_hit_taken", 32'(bp.pred_taken), 32'h1);
    chk("t4_new_hit_target", bp.pred_target, 32'h300);
    do_upd(32'h140, 1'b0, 32'h0, 1'b1, 32'h300);
    chk_out("t4_ctr_was_10", 1'b0, 32'h144, 1'b1, 32'h144);

    // Same-cycle lookup and update: old contents now, new contents next cycle.
    tick(); set_upd(32'h140, 1'b1, 32'h400, 1'b0, 32'h0);
    @(negedge clk);
    chk("t5_same_cycle_taken", 32'(bp.pred_taken), 32'h0);
    chk("t5_same_cycle_target", bp.pred_target, 32'h144);
    tick(); clr();
    @(negedge clk);
    chk_out("t5_next_cycle", 1'b1, 32'h400, 1'b1, 32'h400);

    // Flush with a mispredicted update: table empties, redirect still fires.
    tick(); set_upd(32'h180, 1'b1, 32'h500, 1'b0, 32'h0); bp.flush_table = 1'b1;
    bp.if_pc = 32'h180;
    tick(); clr();
    @(negedge clk);
    chk_out("t6_flush", 1'b0, 32'h184, 1'b1, 32'h500);
    tick(); bp.if_pc = 32'h140;
    @(negedge clk);
    chk("t6_flush_evicted", bp.pred_target, 32'h144);

    // Reset asserted mid-update: update dropped, outputs at reset values at once.
    tick(); bp.if_pc = 32'h100;
    do_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    chk_out("t6_pre_reset", 1'b1, 32'h200, 1'b1, 32'h200);
    tick(); set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    #2 reset_n = 1'b0;
    #1 chk_out("t6_in_reset", 1'b0, 32'h104, 1'b0, 32'h0);
    @(posedge clk); #1;
    clr(); reset_n = 1'b1;
    @(negedge clk);
    chk_out("t6_after_reset", 1'b0, 32'h104, 1'b0, 32'h0);

    // Mixed traffic over several indices/tags, checked by the model each cycle.
    for (int k = 0; k < 24; k++) begin
      logic [31:0] pc;
      logic [31:0] tgt;
      logic [3:0]  kb;
      kb  = 4'(k);
      pc  = 32'h1000 + 32'((k % 5) * 4) + 32'((k % 3) * 32'h40);
      tgt = 32'h2000 + 32'(k * 16);
      tick();
      set_upd(pc, kb[0] ^ kb[2], tgt, kb[1], (k % 4 == 3) ? tgt + 32'd8 : tgt);
      bp.if_pc = pc;
      if (k == 17) bp.flush_table = 1'b1;
    end
    tick(); clr();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
